// File: rtl/fall_lane_engine.sv
// fall_lane_engine: multi-lane falling-character game core (spawn, tick, key hit, miss, score); optional MISS_PENALTY_EN docks a point on unmatched keys
module fall_lane_engine #(
  parameter int LANES = 8,
  parameter int Y_W = 10,
  parameter int SPD_W = 3,
  parameter int LOWER_BOUND = 480,
  parameter int SCORE_W = 8,
  localparam int LW = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [LW-1:0]      spawn_lane,
  input  logic [7:0]         spawn_char,
  input  logic [Y_W-1:0]     spawn_y,
  input  logic [SPD_W-1:0]   spawn_speed,
  input  logic               key_valid,
  input  logic [7:0]         key_ascii,
  input  logic [LW-1:0]      rd_lane,
  output logic               rd_active,
  output logic [7:0]         rd_char,
  output logic [Y_W-1:0]     rd_y,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic               hit
);
  typedef enum logic [1:0] {S_WEL = 2'd0, S_PLAY = 2'd1, S_END = 2'd2} st_e;
  st_e state_q, state_d;
  logic [LANES-1:0] act_q, act_d;
  logic [7:0] chr_q [LANES];
  logic [7:0] chr_d [LANES];
  logic [Y_W-1:0] y_q [LANES];
  logic [Y_W-1:0] y_d [LANES];
  logic [Y_W-1:0] y_t [LANES];
  logic [SPD_W-1:0] spd_q [LANES];
  logic [SPD_W-1:0] spd_d [LANES];
  logic [SCORE_W-1:0] score_q, score_d;
  logic go_q, go_d, hit_q, hit_d, rd_act_q;
  logic [7:0] rd_chr_q;
  logic [Y_W-1:0] rd_y_q;
  logic found, rem, miss;
  logic [LW-1:0] best;
  logic [Y_W-1:0] best_y;
  function automatic logic [Y_W-1:0] sat_add(input logic [Y_W-1:0] a, input logic [SPD_W-1:0] b);
    logic [Y_W:0] s;
    s = {1'b0, a} + (Y_W+1)'(b);
    return s[Y_W] ? '1 : s[Y_W-1:0];
  endfunction
  assign spawn_ready = state_q == S_PLAY && 32'(spawn_lane) < LANES && !act_q[spawn_lane];
  always_comb begin
    found = 1'b0;
    best = '0;
    best_y = '0;
    for (int i = 0; i < LANES; i++) begin
      y_t[i] = sat_add(y_q[i], spd_q[i]);
      if (act_q[i] && chr_q[i] == key_ascii && (!found || y_q[i] > best_y)) begin
        found = 1'b1;
        best = LW'(i);
        best_y = y_q[i];
      end
    end
  end
  assign rem = key_valid && found;
  always_comb begin
    state_d = state_q;
    act_d = act_q;
    chr_d = chr_q;
    y_d = y_q;
    spd_d = spd_q;
    score_d = score_q;
    go_d = go_q;
    hit_d = 1'b0;
    miss = 1'b0;
    case (state_q)
      S_WEL: if (start) begin
        state_d = S_PLAY;
        act_d = '0;
        score_d = '0;
        go_d = 1'b0;
      end
      S_PLAY: begin
        for (int i = 0; i < LANES; i++) begin
          if (tick && act_q[i]) y_d[i] = y_t[i];
          // a lane being hit this cycle cannot also be missed
          if (tick && act_q[i] && !(rem && best == LW'(i)) && 32'(y_t[i]) >= LOWER_BOUND) miss = 1'b1;
        end
        if (rem) begin
          act_d[best] = 1'b0;
          hit_d = 1'b1;
          score_d = &score_q ? score_q : score_q + 1'b1;
        end
`ifdef MISS_PENALTY_EN
        else if (key_valid) score_d = score_q == '0 ? score_q : score_q - 1'b1;
`endif
        if (spawn_valid && spawn_ready) begin
          act_d[spawn_lane] = 1'b1;
          chr_d[spawn_lane] = spawn_char;
          y_d[spawn_lane] = spawn_y;
          spd_d[spawn_lane] = spawn_speed;
        end
        if (miss) begin
          state_d = S_END;
          go_d = 1'b1;
        end
      end
      S_END: if (start) state_d = S_WEL;
      default: state_d = S_WEL;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WEL;
      act_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        chr_q[i] <= '0;
        y_q[i] <= '0;
        spd_q[i] <= '0;
      end
      score_q <= '0;
      go_q <= 1'b0;
      hit_q <= 1'b0;
      rd_act_q <= 1'b0;
      rd_chr_q <= '0;
      rd_y_q <= '0;
    end else begin
      state_q <= state_d;
      act_q <= act_d;
      chr_q <= chr_d;
      y_q <= y_d;
      spd_q <= spd_d;
      score_q <= score_d;
      go_q <= go_d;
      hit_q <= hit_d;
      rd_act_q <= 32'(rd_lane) < LANES ? act_q[rd_lane] : 1'b0;
      rd_chr_q <= 32'(rd_lane) < LANES ? chr_q[rd_lane] : '0;
      rd_y_q <= 32'(rd_lane) < LANES ? y_q[rd_lane] : '0;
    end
  end
  assign state = state_q;
  assign score = score_q;
  assign game_over = go_q;
  assign hit = hit_q;
  assign rd_active = rd_act_q;
  assign rd_char = rd_chr_q;
  assign rd_y = rd_y_q;
endmodule

// File: tb/tb_fall_lane_engine.sv
// tb_fall_lane_engine: directed self-checking bench for fall_lane_engine
module tb_fall_lane_engine;
  logic clk = 0, rst = 1, start = 0, tick = 0, spawn_valid = 0, key_valid = 0;
  logic [2:0] spawn_lane = 0, rd_lane = 0;
  logic [7:0] spawn_char = 0, key_ascii = 0, rd_char, score;
  logic [9:0] spawn_y = 0, rd_y;
  logic [2:0] spawn_speed = 0;
  logic spawn_ready, rd_active, game_over, hit;
  logic [1:0] state;
  int tests = 0, fails = 0;
`ifdef MISS_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif
  fall_lane_engine dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_lane(spawn_lane),
    .spawn_char(spawn_char), .spawn_y(spawn_y), .spawn_speed(spawn_speed),
    .key_valid(key_valid), .key_ascii(key_ascii),
    .rd_lane(rd_lane), .rd_active(rd_active), .rd_char(rd_char), .rd_y(rd_y),
    .state(state), .score(score), .game_over(game_over), .hit(hit)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start;
    start = 1;
    cyc();
    start = 0;
  endtask
  task automatic spawn(input logic [2:0] l, input logic [7:0] c, input logic [9:0] y, input logic [2:0] s);
    spawn_valid = 1; spawn_lane = l; spawn_char = c; spawn_y = y; spawn_speed = s;
    cyc();
    spawn_valid = 0;
  endtask
  task automatic key(input logic [7:0] c);
    key_valid = 1; key_ascii = c;
    cyc();
    key_valid = 0;
  endtask
  task automatic do_tick;
    tick = 1;
    cyc();
    tick = 0;
  endtask
  task automatic rd(input logic [2:0] l);
    rd_lane = l;
    cyc();
  endtask
  initial begin
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    chk("rst_go", game_over, 0);
    chk("rst_hit", hit, 0);
    chk("rst_rd_act", rd_active, 0);
    spawn_lane = 2;
    #1 chk("ready_wel", spawn_ready, 0);
    pulse_start();
    chk("state_play", state, 1);
    chk("ready_play", spawn_ready, 1);
    spawn(2, 8'h41, 0, 3);
    rd(2);
    chk("rd2_act", rd_active, 1);
    chk("rd2_chr", rd_char, 8'h41);
    chk("rd2_y", rd_y, 0);
    spawn_lane = 2;
    #1 chk("ready_busy", spawn_ready, 0);
    do_tick();
    cyc();
    chk("tick_y", rd_y, 3);
    spawn(0, 8'h42, 100, 1);
    spawn(5, 8'h42, 200, 1);
    key(8'h42);
    chk("hitB_hit", hit, 1);
    chk("hitB_score", score, 1);
    cyc();
    chk("hit_pulse_end", hit, 0);
    rd(5);
    chk("lane5_gone", rd_active, 0);
    rd(0);
    chk("lane0_kept", rd_active, 1);
    chk("lane0_y", rd_y, 100);
    spawn(1, 8'h43, 477, 3);
    key_valid = 1; key_ascii = 8'h43; tick = 1;
    cyc();
    key_valid = 0; tick = 0;
    chk("keytick_state", state, 1);
    chk("keytick_score", score, 2);
    rd(1);
    chk("keytick_lane1", rd_active, 0);
    rd(0);
    chk("keytick_lane0_y", rd_y, 101);
    spawn(3, 8'h44, 50, 1);
    spawn(6, 8'h44, 50, 1);
    key(8'h44);
    chk("tie_score", score, 3);
    rd(3);
    chk("tie_lane3", rd_active, 0);
    rd(6);
    chk("tie_lane6", rd_active, 1);
    spawn_valid = 1; spawn_lane = 6; spawn_char = 8'h45; spawn_y = 0; spawn_speed = 1;
    key_valid = 1; key_ascii = 8'h44;
    #1 chk("spawnrem_ready", spawn_ready, 0);
    cyc();
    spawn_valid = 0; key_valid = 0;
    chk("spawnrem_score", score, 4);
    rd(6);
    chk("spawnrem_lane6", rd_active, 0);
    spawn(1, 8'h47, 477, 3);
    do_tick();
    chk("miss_state", state, 2);
    chk("miss_go", game_over, 1);
    rd(1);
    chk("miss_y", rd_y, 480);
    tick = 1; key_valid = 1; key_ascii = 8'h47;
    cyc();
    tick = 0; key_valid = 0;
    rd(1);
    chk("end_frozen_y", rd_y, 480);
    chk("end_frozen_act", rd_active, 1);
    chk("end_score", score, 4);
    spawn_lane = 7;
    #1 chk("end_ready", spawn_ready, 0);
    pulse_start();
    chk("end_to_wel", state, 0);
    chk("wel_go", game_over, 1);
    pulse_start();
    chk("restart_state", state, 1);
    chk("restart_score", score, 0);
    chk("restart_go", game_over, 0);
    rd(1);
    chk("restart_lane1", rd_active, 0);
    spawn(7, 8'h53, 1020, 7);
    do_tick();
    chk("sat_state", state, 2);
    rd(7);
    chk("sat_y", rd_y, 10'h3FF);
    pulse_start(); pulse_start();
    for (int i = 0; i < 255; i++) begin
      spawn(0, 8'h48, 0, 0);
      key(8'h48);
    end
    chk("score_255", score, 255);
    spawn(0, 8'h48, 0, 0);
    key(8'h48);
    chk("score_sat", score, 255);
    chk("score_sat_hit", hit, 1);
    spawn(1, 8'h4D, 479, 1);
    do_tick();
    chk("miss2_state", state, 2);
    pulse_start(); pulse_start();
    for (int i = 0; i < 4; i++) begin
      spawn(0, 8'h48, 0, 0);
      key(8'h48);
    end
    chk("score_4", score, 4);
    key(8'h5A);
    chk("unmatched_score", score, 4 - PEN);
    chk("unmatched_hit", hit, 0);
    spawn(0, 8'h31, 10, 1);
    spawn(1, 8'h32, 10, 1);
    spawn(2, 8'h33, 10, 1);
    rd(0);
    chk("pre_rst_act", rd_active, 1);
    #2 rst = 1;
    #1;
    chk("async_state", state, 0);
    chk("async_score", score, 0);
    chk("async_rd_act", rd_active, 0);
    chk("async_rd_chr", rd_char, 0);
    chk("async_rd_y", rd_y, 0);
    cyc();
    rst = 0;
    cyc();
    chk("post_rst_state", state, 0);
    chk("post_rst_lane0", rd_active, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fall_lane_engine.md
FALL_LANE_ENGINE -- requirements
Module: fall_lane_engine

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning the number of independent falling-character lanes (2..64).
REQ-002 SHALL have parameter Y_W, default 10, meaning the width of a lane's vertical position.
REQ-003 SHALL have parameter SPD_W, default 3, meaning the width of a lane's per-tick speed.
REQ-004 SHALL have parameter LOWER_BOUND, default 480, meaning the vertical position at or beyond which a character counts as missed.
REQ-005 SHALL have parameter SCORE_W, default 8, meaning the score counter width.
REQ-006 SHALL have ports: clk in 1, the single clock; rst in 1, the asynchronous active-high reset.
REQ-007 SHALL have ports: start in 1, a one-cycle screen-advance pulse; tick in 1, a one-cycle move pulse.
REQ-008 SHALL have ports: spawn_valid in 1; spawn_ready out 1; spawn_lane in LW (LW = clog2(LANES)); spawn_char in 8; spawn_y in Y_W; spawn_speed in SPD_W.
REQ-009 SHALL have ports: key_valid in 1, a one-cycle pulse; key_ascii in 8.
REQ-010 SHALL have ports: rd_lane in LW; rd_active out 1; rd_char out 8; rd_y out Y_W, the renderer read port.
REQ-011 SHALL have ports: state out 2 (0 WEL, 1 PLAY, 2 END); score out SCORE_W; game_over out 1; hit out 1, a one-cycle pulse.

Function
REQ-012 SHALL implement FSM WEL->PLAY on start, PLAY->END on miss, END->WEL on start; start SHALL be ignored in PLAY; encoding 3 is unreachable and SHALL recover to WEL on the next cycle.
REQ-013 SHALL, on WEL->PLAY, clear all lane active bits and set score to 0 in the same edge.
REQ-014 SHALL keep per-lane registers active, char, y, speed.
REQ-015 SHALL drive spawn_ready = (state==PLAY) && !active[spawn_lane] combinationally from current registers; spawn_lane >= LANES SHALL give ready 0.
REQ-016 SHALL, on spawn_valid && spawn_ready, load that lane with char, y, speed and active=1 at the next edge.
REQ-017 SHALL, on tick in PLAY, add speed to y for every active lane, saturating at 2^Y_W-1.
REQ-018 SHALL, when any active lane's post-tick y >= LOWER_BOUND, enter END at that same edge and set game_over=1; game_over SHALL stay 1 until WEL->PLAY.
REQ-019 SHALL, on key_valid in PLAY, select among active lanes with char==key_ascii the one with largest y, ties to lowest index, compare against pre-edge values, clear its active bit, pulse hit for one cycle, and increment score saturating at all-ones.
REQ-020 SHALL, when key removal and tick affect the same lane in one cycle, apply removal, excluding that lane from the REQ-018 miss check.
REQ-021 SHALL evaluate a spawn and a removal on the same lane in one cycle using pre-edge active, so the spawn is not accepted because spawn_ready=0.
REQ-022 SHALL freeze all lanes and score in WEL and END; spawn, tick and key SHALL have no effect there.
REQ-023 SHALL register rd_active/rd_char/rd_y from lane rd_lane with one-cycle latency; rd_lane >= LANES SHALL return all zeros.

Reset
REQ-024 SHALL, on rst asserted, immediately set state=WEL, all active=0, char/y/speed=0, score=0, game_over=0, hit=0, rd_* = 0, including mid-PLAY.
REQ-025 SHALL resume normal operation on the first clk edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro MISS_PENALTY_EN defined, decrement score by 1 (saturating at 0) on a PLAY key_valid that matches no active lane.
REQ-027 SHALL, with MISS_PENALTY_EN undefined, ignore unmatched keys with no score change.

Verification
REQ-028 Reset, start, spawn lane 2 'A' y=0 speed=3 -> spawn_ready=0 before start, 1 after; rd_lane=2 gives active=1, char=8'h41, y=0 one cycle later.
REQ-029 Lane 0 'B' y=100 and lane 5 'B' y=200, key 8'h42 -> lane 5 cleared, lane 0 remains, hit pulses once, score=1.
REQ-030 Lane 1 y=477 speed=3, tick -> y=480, state=END, game_over=1; a following tick/key changes nothing; start -> WEL; start -> PLAY with score=0 and all lanes inactive.
REQ-031 Lane 1 'C' y=477 speed=3, key 8'h43 and tick in the same cycle -> lane cleared, state stays PLAY, score+1.
REQ-032 score=255 (SCORE_W=8) plus hit -> stays 255; unmatched key at score=4 -> 3 with MISS_PENALTY_EN, 4 without.
REQ-033 rst pulsed mid-PLAY with 3 active lanes -> outputs zero and state=WEL without a clock edge.
